kernel_launch_scheduler: RTL and testbench

//   Successor to the single-kernel dispatcher. Queues up to QUEUE_DEPTH kernel launch descriptors
//   and runs them one after another, in order. For each kernel it hands out blocks to NUM_CORES

---
 rtl/kernel_launch_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_kernel_launch_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_launch_scheduler.sv
// kernel_launch_scheduler
//   Queues kernel launch descriptors in a small FIFO and runs the kernels strictly in order.
//   For the running kernel, blocks are handed out one per cycle to the lowest-index free
//   compute core. kernel_done pulses once all blocks of a kernel have completed.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   launch_*_i / launch_ready_o  host descriptor handshake (valid/ready)
//   active_*_o                 configuration of the running kernel, shared by all cores
//   core_reset_o               1-cycle pulse on the dispatch cycle of core i
//   core_start_o               high while core i owns a block
//   core_block_id_o            block id for core i in slice [i*DATA_WIDTH +: DATA_WIDTH]
//   core_done_i                core i finished its block (ignored unless core_start_o[i])
//   kernel_done_o              1-cycle pulse per finished kernel
//   busy_o                     a kernel is loading or dispatching
//   queue_count_o              descriptors waiting in the FIFO
module kernel_launch_scheduler #(
    parameter int unsigned NUM_CORES   = 4,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            launch_valid_i,
    output logic                            launch_ready_o,
    input  logic [DATA_WIDTH-1:0]           launch_base_instr_i,
    input  logic [DATA_WIDTH-1:0]           launch_base_data_i,
    input  logic [DATA_WIDTH-1:0]           launch_num_blocks_i,
    input  logic [DATA_WIDTH-1:0]           launch_warps_per_blk_i,
    output logic [DATA_WIDTH-1:0]           active_base_instr_o,
    output logic [DATA_WIDTH-1:0]           active_base_data_o,
    output logic [DATA_WIDTH-1:0]           active_warps_per_blk_o,
    output logic [NUM_CORES-1:0]            core_reset_o,
    output logic [NUM_CORES-1:0]            core_start_o,
    output logic [NUM_CORES*DATA_WIDTH-1:0] core_block_id_o,
    input  logic [NUM_CORES-1:0]            core_done_i,
    output logic                            kernel_done_o,
    output logic                            busy_o,
    output logic [$clog2(QUEUE_DEPTH):0]    queue_count_o
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef struct packed {
        word_t base_instr;
        word_t base_data;
        word_t num_blocks;
        word_t warps_per_blk;
    } desc_t;

    typedef enum logic [1:0] {StIdle, StLoad, StDispatch} state_e;

    state_e                state_q, state_d;
    desc_t                 fifo_q [QUEUE_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q;
    desc_t                 active_q;
    word_t                 dispatched_q, dispatched_d;
    word_t                 done_q, done_d;
    logic [NUM_CORES-1:0]  core_start_q, core_start_d;
    word_t                 block_id_q [NUM_CORES];

    logic                  push, pop, disp;
    logic [NUM_CORES-1:0]  done_hit, free, first_free, disp_oh;
    word_t                 done_inc, done_sum;

    always_comb begin
        launch_ready_o = (count_q < CntW'(QUEUE_DEPTH));
        push           = launch_valid_i && launch_ready_o;

        // Completions only count for cores that actually own a block.
        done_hit = core_done_i & core_start_q;
        done_inc = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            done_inc = done_inc + word_t'(done_hit[i]);
        end
        done_sum = done_q + done_inc;

        // A core completing this cycle is still marked busy, so it is reusable next cycle.
        free       = ~core_start_q;
        first_free = free & (~free + NUM_CORES'(1));

        state_d       = state_q;
        pop           = 1'b0;
        disp          = 1'b0;
        kernel_done_o = 1'b0;
        dispatched_d  = dispatched_q;
        done_d        = done_q;

        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                dispatched_d = '0;
                done_d       = '0;
                if (active_q.num_blocks == '0) begin
                    kernel_done_o = 1'b1;
                    state_d       = StIdle;
                end else begin
                    state_d = StDispatch;
                end
            end
            StDispatch: begin
                done_d = done_sum;
                if ((dispatched_q < active_q.num_blocks) && (free != '0)) begin
                    disp         = 1'b1;
                    dispatched_d = dispatched_q + word_t'(1);
                end
                if (done_sum == active_q.num_blocks) begin
                    kernel_done_o = 1'b1;
                    // Chain straight into the next queued kernel without an idle cycle.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        disp_oh      = disp ? first_free : '0;
        core_start_d = (core_start_q & ~done_hit) | disp_oh;

        core_reset_o    = disp_oh;
        core_start_o    = core_start_q;
        core_block_id_o = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_block_id_o[i*DATA_WIDTH +: DATA_WIDTH] = disp_oh[i] ? dispatched_q : block_id_q[i];
        end

        active_base_instr_o    = active_q.base_instr;
        active_base_data_o     = active_q.base_data;
        active_warps_per_blk_o = active_q.warps_per_blk;
        busy_o                 = (state_q != StIdle);
        queue_count_o          = count_q;
    end

    // Descriptor storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{base_instr:    launch_base_instr_i,
                                  base_data:     launch_base_data_i,
                                  num_blocks:    launch_num_blocks_i,
                                  warps_per_blk: launch_warps_per_blk_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            active_q     <= '0;
            dispatched_q <= '0;
            done_q       <= '0;
            core_start_q <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                block_id_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            dispatched_q <= dispatched_d;
            done_q       <= done_d;
            core_start_q <= core_start_d;
            count_q      <= count_q + CntW'(push) - CntW'(pop);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                active_q <= fifo_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (disp_oh[i]) begin
                    block_id_q[i] <= dispatched_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_kernel_launch_scheduler.sv
// Testbench for kernel_launch_scheduler: directed scenarios plus randomized kernels, checked
// every cycle against a queue-based reference model of the launch/dispatch rules.
module tb_kernel_launch_scheduler;

    localparam int NC = 4;
    localparam int QD = 4;
    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               launch_valid;
    logic               launch_ready;
    logic [DW-1:0]      l_bi, l_bd, l_nb, l_wp;
    logic [DW-1:0]      a_bi, a_bd, a_wp;
    logic [NC-1:0]      core_reset, core_start, core_done;
    logic [NC*DW-1:0]   core_block_id;
    logic               kernel_done, busy;
    logic [$clog2(QD):0] queue_count;

    always #5 clk = ~clk;

    kernel_launch_scheduler #(
        .NUM_CORES  (NC),
        .QUEUE_DEPTH(QD),
        .DATA_WIDTH (DW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .launch_valid_i        (launch_valid),
        .launch_ready_o        (launch_ready),
        .launch_base_instr_i   (l_bi),
        .launch_base_data_i    (l_bd),
        .launch_num_blocks_i   (l_nb),
        .launch_warps_per_blk_i(l_wp),
        .active_base_instr_o   (a_bi),
        .active_base_data_o    (a_bd),
        .active_warps_per_blk_o(a_wp),
        .core_reset_o          (core_reset),
        .core_start_o          (core_start),
        .core_block_id_o       (core_block_id),
        .core_done_i           (core_done),
        .kernel_done_o         (kernel_done),
        .busy_o                (busy),
        .queue_count_o         (queue_count)
    );

    typedef struct {
        logic [DW-1:0] bi;
        logic [DW-1:0] bd;
        logic [DW-1:0] nb;
        logic [DW-1:0] wp;
    } desc_t;

    // Reference model: FIFO contents, current kernel, per-core ownership.
    desc_t         q_m[$];
    desc_t         cur_m;
    bit            loading_m, running_m;
    logic [DW-1:0] next_id_m, done_n_m;
    logic [NC-1:0] busy_m;
    logic [DW-1:0] blk_m [NC];
    int            tmr_m [NC];

    // Stimulus controls.
    bit    lv;
    desc_t drv;
    bit    hold, spur_en;
    int    lat_fixed;
    int    lat_q[$];

    int n_pass, n_fail, n_total;
    int obs_resets, obs_kd;
    int base_resets, base_kd;

    task automatic chk(input string tag, input logic [NC*DW-1:0] obs, input logic [NC*DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        n_total++;
        n_fail++;
        $error("FAIL %s observed=timeout expected=completion", tag);
    endtask

    function automatic int pick_lat();
        if (lat_q.size() > 0) return lat_q.pop_front();
        if (lat_fixed >= 0) return lat_fixed;
        return int'($urandom_range(0, 5));
    endfunction

    function automatic desc_t mk(input int nb);
        desc_t d;
        d.bi = $urandom;
        d.bd = $urandom;
        d.nb = DW'(nb);
        d.wp = DW'($urandom_range(1, 8));
        return d;
    endfunction

    task automatic model_reset();
        q_m.delete();
        lat_q.delete();
        loading_m = 0;
        running_m = 0;
        next_id_m = '0;
        done_n_m  = '0;
        busy_m    = '0;
        cur_m     = '{default: '0};
        for (int i = 0; i < NC; i++) begin
            blk_m[i] = '0;
            tmr_m[i] = 0;
        end
    endtask

    // One clock cycle: drive inputs, compare every output to the model, advance the model.
    task automatic step();
        logic [NC-1:0]    dmask, rst_exp;
        logic [NC*DW-1:0] ids_exp;
        int               compl, dc;
        bit               fin, kd_exp, disp, push, pop;
        @(negedge clk);
        launch_valid = lv;
        l_bi = drv.bi;
        l_bd = drv.bd;
        l_nb = drv.nb;
        l_wp = drv.wp;
        for (int i = 0; i < NC; i++) begin
            if (busy_m[i]) core_done[i] = !hold && (tmr_m[i] == 0);
            else           core_done[i] = spur_en && ($urandom_range(0, 2) == 0);
        end
        #1;
        dmask  = core_done & busy_m;
        compl  = $countones(dmask);
        fin    = running_m && ((done_n_m + DW'(compl)) == cur_m.nb);
        kd_exp = (loading_m && (cur_m.nb == '0)) || fin;
        dc = -1;
        for (int i = NC - 1; i >= 0; i--) if (!busy_m[i]) dc = i;
        disp = running_m && (next_id_m < cur_m.nb) && (dc >= 0);
        rst_exp = '0;
        for (int i = 0; i < NC; i++) ids_exp[i*DW +: DW] = blk_m[i];
        if (disp) begin
            rst_exp[dc] = 1'b1;
            ids_exp[dc*DW +: DW] = next_id_m;
        end

        chk("launch_ready", launch_ready, q_m.size() < QD);
        chk("queue_count", queue_count, q_m.size());
        chk("busy", busy, loading_m || running_m);
        chk("core_start", core_start, busy_m);
        chk("core_reset", core_reset, rst_exp);
        chk("core_block_id", core_block_id, ids_exp);
        chk("kernel_done", kernel_done, kd_exp);
        chk("active_base_instr", a_bi, cur_m.bi);
        chk("active_base_data", a_bd, cur_m.bd);
        chk("active_warps", a_wp, cur_m.wp);
        obs_resets += $countones(core_reset);
        obs_kd     += int'(kernel_done);

        push = lv && (q_m.size() < QD);
        pop  = 0;
        for (int i = 0; i < NC; i++) begin
            if (busy_m[i] && !dmask[i] && !hold && tmr_m[i] > 0) tmr_m[i]--;
        end
        busy_m = busy_m & ~dmask;
        if (loading_m) begin
            loading_m = 0;
            next_id_m = '0;
            done_n_m  = '0;
            running_m = (cur_m.nb != '0);
        end else if (running_m) begin
            if (disp) begin
                busy_m[dc] = 1'b1;
                blk_m[dc]  = next_id_m;
                tmr_m[dc]  = pick_lat();
                next_id_m  = next_id_m + 1;
            end
            done_n_m = done_n_m + DW'(compl);
            if (fin) begin
                running_m = 0;
                pop = (q_m.size() > 0);
            end
        end else begin
            pop = (q_m.size() > 0);
        end
        if (pop) begin
            cur_m = q_m.pop_front();
            loading_m = 1;
        end
        if (push) q_m.push_back(drv);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        lv = 0;
        launch_valid = 1'b0;
        core_done = '0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic push_kernel(input desc_t d, input int max);
        bit acc;
        lv  = 1;
        drv = d;
        for (int c = 0; c < max; c++) begin
            acc = (q_m.size() < QD);
            step();
            if (acc) begin
                lv = 0;
                return;
            end
        end
        lv = 0;
        bound_fail("push_accept");
    endtask

    task automatic run_idle(input int max);
        for (int c = 0; c < max; c++) begin
            if (!loading_m && !running_m && q_m.size() == 0 && busy_m == '0) return;
            step();
        end
        bound_fail("run_idle");
    endtask

    task automatic mark();
        base_resets = obs_resets;
        base_kd     = obs_kd;
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        obs_resets = 0; obs_kd = 0;
        reset = 1'b0; launch_valid = 1'b0; core_done = '0;
        l_bi = '0; l_bd = '0; l_nb = '0; l_wp = '0;
        lv = 0; drv = '{default: '0};
        hold = 0; spur_en = 0; lat_fixed = -1;

        // Reset state.
        do_reset();
        chk("rst_launch_ready", launch_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_queue_count", queue_count, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_kernel_done", kernel_done, 1'b0);
        chk("rst_active_instr", a_bi, 0);

        // Five blocks on four cores, cores ack after 10 cycles.
        lat_fixed = 10;
        mark();
        push_kernel(mk(5), 10);
        run_idle(200);
        chk("s1_resets", obs_resets - base_resets, 5);
        chk("s1_kernel_done", obs_kd - base_kd, 1);

        // Empty kernel: done in LOAD, no core activity.
        mark();
        push_kernel(mk(0), 10);
        run_idle(50);
        chk("s2_resets", obs_resets - base_resets, 0);
        chk("s2_kernel_done", obs_kd - base_kd, 1);

        // Stall the FSM and overfill the queue.
        lat_fixed = -1;
        hold = 1;
        mark();
        push_kernel(mk(4), 10);
        for (int c = 0; c < 30 && busy_m != '1; c++) step();
        for (int k = 0; k < 4; k++) push_kernel(mk($urandom_range(1, 6)), 10);
        drv = mk(3);
        lv  = 1;
        for (int c = 0; c < 3; c++) step();
        chk("s3_queue_full", queue_count, 4);
        chk("s3_ready_low", launch_ready, 1'b0);
        hold = 0;
        push_kernel(drv, 200);
        run_idle(600);
        chk("s3_kernel_done", obs_kd - base_kd, 6);

        // Two queued kernels chain back to back.
        lat_fixed = 2;
        mark();
        push_kernel(mk(3), 10);
        push_kernel(mk(2), 10);
        run_idle(100);
        chk("s4_resets", obs_resets - base_resets, 5);
        chk("s4_kernel_done", obs_kd - base_kd, 2);

        // Reset while two cores are busy.
        hold = 1;
        mark();
        push_kernel(mk(3), 10);
        push_kernel(mk(2), 10);
        for (int c = 0; c < 20 && $countones(busy_m) < 2; c++) step();
        do_reset();
        chk("s5_core_start", core_start, 0);
        chk("s5_queue_count", queue_count, 0);
        chk("s5_busy", busy, 1'b0);
        chk("s5_kernel_done", kernel_done, 1'b0);
        hold = 0;
        for (int c = 0; c < 3; c++) step();
        chk("s5_no_done", obs_kd - base_kd, 0);

        // Two cores finish together while idle cores see spurious done.
        spur_en = 1;
        lat_fixed = -1;
        mark();
        lat_q.push_back(4);
        lat_q.push_back(3);
        push_kernel(mk(2), 10);
        run_idle(100);
        chk("s6_kernel_done", obs_kd - base_kd, 1);

        // Randomized kernels with gaps.
        mark();
        for (int k = 0; k < 16; k++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) step();
            push_kernel(mk($urandom_range(0, 7)), 200);
        end
        run_idle(3000);
        chk("rand_kernel_done", obs_kd - base_kd, 16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
